// File: rtl/afec_buf_wr.sv
// afec_buf_wr
// Frame writer between the AFEC sample path and the SRAM controller's AFEC port.
// It accepts DW-bit samples on a valid/ready handshake and writes one frame of
// DEPTH samples to SRAM words BASE..BASE+DEPTH-1, with addresses taken modulo 2^AW.
// SRAM ownership is requested only while a frame is in flight.
//
// State table:
//   IDLE  | no frame; SRAM port released; waiting for i_start
//   ARM   | ownership requested; one cycle for the controller mux to settle
//   WRITE | ready=1; every accepted sample is registered as an SRAM write
//   LAST  | final sample written; release the port, pulse done, count the frame
//
// Ports:
//   i_ck, i_rst                  clock and synchronous active-high reset
//   i_start, i_abort             frame start and terminate pulses (abort wins)
//   i_smp_valid/i_smp_data       sample input; o_smp_ready is the handshake
//   o_afec_data_access           SRAM ownership request
//   o_afec_mem_ck/csb/web/a/di   SRAM write port (csb/web active-low)
//   o_busy, o_done, o_ovf        status: frame in flight, completion pulse, sticky overflow
//   o_frm_cnt                    completed frames, wraps 255 -> 0
module afec_buf_wr #(
  parameter int DEPTH = 560,
  parameter int BASE  = 0,
  parameter int AW    = 12,
  parameter int DW    = 14
) (
  input  logic          i_ck,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_smp_valid,
  input  logic [DW-1:0] i_smp_data,
  output logic          o_smp_ready,
  output logic          o_afec_data_access,
  output logic          o_afec_mem_ck,
  output logic          o_afec_mem_csb,
  output logic          o_afec_mem_web,
  output logic [AW-1:0] o_afec_mem_a,
  output logic [DW-1:0] o_afec_mem_di,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_ovf,
  output logic [7:0]    o_frm_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WRITE, S_LAST} state_t;

  localparam logic [AW-1:0] BASE_A   = AW'(BASE);
  localparam logic [11:0]   LAST_IDX = 12'(DEPTH - 1);

  state_t        r_state;
  logic [11:0]   r_idx;
  logic          r_access;
  logic          r_csb;
  logic          r_web;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_di;
  logic          r_busy;
  logic          r_done;
  logic          r_ovf;
  logic [7:0]    r_frm_cnt;

  logic w_ready;
  logic w_accept;
  logic w_last;

  // Ready depends on state only, so there is no combinational path from valid.
  assign w_ready  = (r_state == S_WRITE);
  assign w_accept = w_ready & i_smp_valid;
  assign w_last   = (r_idx == LAST_IDX);

  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_access  <= 1'b0;
      r_csb     <= 1'b1;
      r_web     <= 1'b1;
      r_a       <= '0;
      r_di      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_frm_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      // A sample offered while we own the port but cannot take it is lost.
      // In IDLE the port is not owned, so offered samples drop silently.
      if (r_access && !w_ready && i_smp_valid) r_ovf <= 1'b1;

      if (i_abort && (r_state != S_IDLE)) begin
        r_state  <= S_IDLE;
        r_csb    <= 1'b1;
        r_web    <= 1'b1;
        r_access <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              r_state  <= S_ARM;
              r_access <= 1'b1;
              r_busy   <= 1'b1;
              r_idx    <= '0;
              r_ovf    <= 1'b0;
            end
          end
          S_ARM: r_state <= S_WRITE;
          S_WRITE: begin
            if (w_accept) begin
              r_csb <= 1'b0;
              r_web <= 1'b0;
              r_a   <= BASE_A + AW'(r_idx);
              r_di  <= i_smp_data;
              r_idx <= r_idx + 12'd1;
              if (w_last) r_state <= S_LAST;
            end else begin
              r_csb <= 1'b1;
              r_web <= 1'b1;
            end
          end
          S_LAST: begin
            r_csb     <= 1'b1;
            r_web     <= 1'b1;
            r_access  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_frm_cnt <= r_frm_cnt + 8'd1;
            r_state   <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // SRAM runs on the inverted clock so it samples the registered port mid-cycle.
  assign o_afec_mem_ck      = ~i_ck;
  assign o_smp_ready        = w_ready;
  assign o_afec_data_access = r_access;
  assign o_afec_mem_csb     = r_csb;
  assign o_afec_mem_web     = r_web;
  assign o_afec_mem_a       = r_a;
  assign o_afec_mem_di      = r_di;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_ovf              = r_ovf;
  assign o_frm_cnt          = r_frm_cnt;

endmodule
